pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised elastic pipeline stage register, the successor to the fixed-field inter-stage registers between decode, execute, memory and writeback. It carries an opaque control vector and data vector with a valid/ready handshake, synchronous flush and bubble insertion. With `SKID=1` it adds a 2-entry skid buffer so `in_ready_o` is registered and breaks the backpressure timing path. One instance per pipeline boundary; field packing is done by the instantiating stage.

## Interface
- `CTRL_W`, 10, control-bit vector width (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[2:0], ALUSrc, Branch, spare); zeroed on every bubble.
- `DATA_W`, 128, payload width (RS1data, RS2data, instruction, imm_ext); must be ≥1.
- `SKID`, 1, 0 = single register with combinational ready; 1 = main plus skid entry with registered ready.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  synchronous kill of all held entries and the current input.
- `in_valid_i`  in  1  upstream entry valid.
- `in_ready_o`  out  1  stage accepts input this cycle.
- `in_ctrl_i`  in  CTRL_W  upstream control vector.
- `in_data_i`  in  DATA_W  upstream payload.
- `out_valid_o`  out  1  main entry valid.
- `out_ready_i`  in  1  downstream consumes main entry this cycle.
- `out_ctrl_o`  out  CTRL_W  main-entry control; all-zero when `out_valid_o`=0.
- `out_data_o`  out  DATA_W  main-entry payload; all-zero when `out_valid_o`=0.
- `occupancy_o`  out  2  entries held (0..1 for SKID=0, 0..2 for SKID=1).

## Operation
- Transfer in: `in_valid_i & in_ready_o`; out: `out_valid_o & out_ready_i`.
- Bubble rule: any invalid entry stores zero ctrl and zero data; downstream never sees stale write enables.
- Flush (priority over everything except reset): next edge clears all entries to zero/invalid; an input accepted in the flush cycle is dropped; `in_ready_o` stays per normal rule that cycle.
- SKID=0: `in_ready_o = ~out_valid_o | out_ready_i`. Edge: accept → load main; else if out transfer → clear main; else hold.
- SKID=1, states EMPTY / ONE / FULL (main always filled before skid), `in_ready_o = (state != FULL)`:
  - EMPTY: in transfer → ONE (load main); else stay.
  - ONE: in & out → ONE (main ← input); in only → FULL (skid ← input); out only → EMPTY; neither → stay.
  - FULL: out transfer → ONE (main ← skid, skid cleared); else hold. No input accepted.
  - Ordering preserved: skid entry always leaves before any later input.
- `occupancy_o` = number of valid entries, registered.

## Timing
- Reset (async assert, sync-safe deassert): all entries zero/invalid; `out_valid_o`=0, `out_ctrl_o`=0, `out_data_o`=0, `occupancy_o`=0, `in_ready_o`=1.
- Latency: input accepted at edge N appears on outputs after edge N (1 cycle), both modes.
- Throughput: 1 entry/cycle when `out_ready_i` held high.
- SKID=1: `in_ready_o` and all outputs are flop-driven; no combinational path in→out. SKID=0: `out_ready_i`→`in_ready_o` combinational.
- Reset mid-operation: immediate clear, no entry survives. Flush and reset together: reset wins.
- Flush with FULL and `out_ready_i`=1: the consumed main entry is delivered this cycle; skid and input are discarded.

## Structure
- Package `pipe_pkg`: state enum `pipe_state_t` {EMPTY, ONE, FULL}; default width constants; ID/EX ctrl bit-offset localparams for packing.
- Sub-module `pipe_slot`: one valid+ctrl+data register with load, clear and hold controls; instantiated once (SKID=0) or twice (SKID=1).

## Test plan
- Reset release, idle: `occupancy_o`=0, `out_valid_o`=0, `in_ready_o`=1, outputs zero.
- Streaming, SKID=1, `out_ready_i`=1, inputs ctrl 0x3FF/data k for k=1..8: same values out one cycle later, no gaps, `occupancy_o`=1.
- Backpressure, SKID=1: push A,B with `out_ready_i`=0 → `occupancy_o`=2, `in_ready_o`=0, C held upstream; release → A,B,C in order.
- Flush while FULL with `in_valid_i`=1 → next cycle `out_valid_o`=0, ctrl/data 0, `occupancy_o`=0; dropped input never appears.
- SKID=0, `out_valid_o`=1, toggle `out_ready_i` → `in_ready_o` follows same cycle; hold keeps data stable.
- Assert `rst_i`=0 mid-stream at occupancy 2 → outputs zero immediately, before next edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the elastic pipeline stage register:
//   - default control / payload widths
//   - ID/EX control-vector bit offsets used by the instantiating stage to pack
//     and unpack the opaque control vector
//   - skid-mode occupancy state enum and its occupancy decode
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 128;

  // ID/EX control vector layout (bit offsets inside ctrl)
  localparam int unsigned IDEX_REG_WRITE  = 0;
  localparam int unsigned IDEX_MEM_TO_REG = 1;
  localparam int unsigned IDEX_MEM_READ   = 2;
  localparam int unsigned IDEX_MEM_WRITE  = 3;
  localparam int unsigned IDEX_ALU_OP_LSB = 4;  // ALUOp occupies [6:4]
  localparam int unsigned IDEX_ALU_OP_W   = 3;
  localparam int unsigned IDEX_ALU_SRC    = 7;
  localparam int unsigned IDEX_BRANCH     = 8;
  localparam int unsigned IDEX_SPARE      = 9;

  // Entries held in skid mode: main is always filled before skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
//   One pipeline entry: valid flag plus control and payload registers.
//   clear_i has priority over load_i; with neither asserted the entry holds.
//   A cleared (invalid) entry always holds all-zero ctrl and data.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   clear_i           empty the entry (zero ctrl/data)
//   load_i            capture ctrl_i/data_i as a valid entry
//   ctrl_i, data_i    entry contents to load
//   valid_o           entry valid
//   ctrl_o, data_o    stored contents (zero when invalid)
// -----------------------------------------------------------------------------
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: ctrl and data are reset along with valid, not just valid. The
  // outputs are specified as zero whenever the entry is invalid, so an
  // unreset payload would leak X/stale write enables downstream.
  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic pipeline stage register carrying an opaque control vector and a
//   payload with valid/ready handshake, synchronous flush and bubble zeroing.
//   SKID=0: single entry, in_ready_o is combinational from out_ready_i.
//   SKID=1: main + skid entry, in_ready_o and all outputs come from flops.
// Ports:
//   clk_i, rst_i             clock, asynchronous active-low reset
//   flush_i                  kill held entries and the current input
//   in_valid_i / in_ready_o  upstream handshake
//   in_ctrl_i, in_data_i     upstream entry
//   out_valid_o / out_ready_i downstream handshake (main entry)
//   out_ctrl_o, out_data_o   main entry, zero when out_valid_o=0
//   occupancy_o              number of entries held
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  if (SKID == 0) begin : g_single

    logic main_load;
    logic main_clear;

    assign in_ready_o = ~out_valid_o | out_ready_i;

    // An accepted input is dropped under flush; otherwise a departing entry
    // is only cleared when nothing replaces it.
    assign main_load  = in_xfer & ~flush_i;
    assign main_clear = flush_i | (out_xfer & ~in_xfer);

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (main_clear),
      .load_i  (main_load),
      .ctrl_i  (in_ctrl_i),
      .data_i  (in_data_i),
      .valid_o (out_valid_o),
      .ctrl_o  (out_ctrl_o),
      .data_o  (out_data_o)
    );

    assign occupancy_o = {1'b0, out_valid_o};

  end else begin : g_skid

    pipe_state_t       state_q, state_d;
    logic [1:0]        occ_q;
    logic              main_load, main_clear, main_from_skid;
    logic              skid_load, skid_clear;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl, main_ctrl_in;
    logic [DATA_W-1:0] skid_data, main_data_in;

    // State register; occupancy is registered alongside it.
    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        state_q <= EMPTY;
        occ_q   <= 2'd0;
      end else begin
        state_q <= state_d;
        occ_q   <= state_occupancy(state_d);
      end
    end

    // Next-state logic.
    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
      state_d = state_q;
      if (flush_i) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY:   if (in_xfer) state_d = ONE;
          ONE: begin
            if (in_xfer && !out_xfer)      state_d = FULL;
            else if (!in_xfer && out_xfer) state_d = EMPTY;
          end
          FULL:    if (out_xfer) state_d = ONE;
          default: state_d = EMPTY;
        endcase
      end
    end

    // Slot controls. In FULL no input is accepted, so the skid entry always
    // moves to main before any later input can enter.
    always_comb begin
      main_load      = 1'b0;
      main_clear     = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      skid_clear     = 1'b0;
      if (flush_i) begin
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end else begin
        case (state_q)
          EMPTY: main_load = in_xfer;
          ONE: begin
            if (in_xfer && out_xfer) main_load  = 1'b1;
            else if (in_xfer)        skid_load  = 1'b1;
            else if (out_xfer)       main_clear = 1'b1;
          end
          FULL: begin
            if (out_xfer) begin
              main_load      = 1'b1;
              main_from_skid = 1'b1;
              skid_clear     = 1'b1;
            end
          end
          default: begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
          end
        endcase
      end
    end

    assign main_ctrl_in = main_from_skid ? skid_ctrl : in_ctrl_i;
    assign main_data_in = main_from_skid ? skid_data : in_data_i;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (main_clear),
      .load_i  (main_load),
      .ctrl_i  (main_ctrl_in),
      .data_i  (main_data_in),
      .valid_o (out_valid_o),
      .ctrl_o  (out_ctrl_o),
      .data_o  (out_data_o)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (skid_clear),
      .load_i  (skid_load),
      .ctrl_i  (in_ctrl_i),
      .data_i  (in_data_i),
      .valid_o (skid_valid),
      .ctrl_o  (skid_ctrl),
      .data_o  (skid_data)
    );

    // The skid entry is valid exactly in FULL, so its valid flop gives a
    // registered ready without a combinational path from out_ready_i.
    assign in_ready_o  = ~skid_valid;
    assign occupancy_o = occ_q;

  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, each with a
//   queue scoreboard of entries held, plus a vector table for SKID=0 and
//   directed sequences for the SKID=1 corner cases.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 128;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } entry_t;

  typedef struct {
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          flush;
    logic          exp_ready;
    logic          exp_valid;
    logic [CW-1:0] exp_ctrl;
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_occ;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i;

  // SKID=1 instance signals
  logic          s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [CW-1:0] s_in_ctrl, s_out_ctrl;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [1:0]    s_occ;

  // SKID=0 instance signals
  logic          n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [CW-1:0] n_in_ctrl, n_out_ctrl;
  logic [DW-1:0] n_in_data, n_out_data;
  logic [1:0]    n_occ;

  int n_checks = 0;
  int n_fail   = 0;

  entry_t sq[$];
  entry_t nq[$];
  vec_t   vecs[11];

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_skid (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (s_flush),
    .in_valid_i  (s_in_valid),
    .in_ready_o  (s_in_ready),
    .in_ctrl_i   (s_in_ctrl),
    .in_data_i   (s_in_data),
    .out_valid_o (s_out_valid),
    .out_ready_i (s_out_ready),
    .out_ctrl_o  (s_out_ctrl),
    .out_data_o  (s_out_data),
    .occupancy_o (s_occ)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_noskid (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (n_flush),
    .in_valid_i  (n_in_valid),
    .in_ready_o  (n_in_ready),
    .in_ctrl_i   (n_in_ctrl),
    .in_data_i   (n_in_data),
    .out_valid_o (n_out_valid),
    .out_ready_i (n_out_ready),
    .out_ctrl_o  (n_out_ctrl),
    .out_data_o  (n_out_data),
    .occupancy_o (n_occ)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    s_in_valid = v;
    s_in_ctrl  = c;
    s_in_data  = d;
  endtask

  // Scoreboard for SKID=1: queue holds the entries the stage should contain.
  always @(negedge clk) begin : mon_skid
    entry_t e;
    if (!rst_i) begin
      sq.delete();
    end else begin
      check("s_occ_model", s_occ, sq.size());
      check("s_ready_model", s_in_ready, (sq.size() != 2));
      check("s_valid_model", s_out_valid, (sq.size() != 0));
      if (!s_out_valid) begin
        check("s_bubble_ctrl", s_out_ctrl, '0);
        check("s_bubble_data", s_out_data, '0);
      end
      if (s_out_valid && s_out_ready) begin
        if (sq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL s_unexpected_out: got ctrl %0h data %0h, no entry expected", s_out_ctrl, s_out_data);
        end else begin
          e = sq.pop_front();
          check("s_sb_ctrl", s_out_ctrl, e.ctrl);
          check("s_sb_data", s_out_data, e.data);
        end
      end
      if (s_in_valid && s_in_ready && !s_flush) sq.push_back('{ctrl: s_in_ctrl, data: s_in_data});
      if (s_flush) sq.delete();
    end
  end

  // Scoreboard for SKID=0.
  always @(negedge clk) begin : mon_noskid
    entry_t e;
    if (!rst_i) begin
      nq.delete();
    end else begin
      check("n_occ_model", n_occ, nq.size());
      check("n_ready_model", n_in_ready, (nq.size() == 0) || n_out_ready);
      if (!n_out_valid) begin
        check("n_bubble_ctrl", n_out_ctrl, '0);
        check("n_bubble_data", n_out_data, '0);
      end
      if (n_out_valid && n_out_ready) begin
        if (nq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL n_unexpected_out: got ctrl %0h data %0h, no entry expected", n_out_ctrl, n_out_data);
        end else begin
          e = nq.pop_front();
          check("n_sb_ctrl", n_out_ctrl, e.ctrl);
          check("n_sb_data", n_out_data, e.data);
        end
      end
      if (n_in_valid && n_in_ready && !n_flush) nq.push_back('{ctrl: n_in_ctrl, data: n_in_data});
      if (n_flush) nq.delete();
    end
  end

  initial begin
    // in_valid, ctrl, data, out_ready, flush | exp ready, valid, ctrl, data, occ
    vecs[0]  = '{1'b1, 10'h001, 128'h11, 1'b0, 1'b0, 1'b1, 1'b1, 10'h001, 128'h11, 2'd1};
    vecs[1]  = '{1'b1, 10'h002, 128'h22, 1'b0, 1'b0, 1'b0, 1'b1, 10'h001, 128'h11, 2'd1};
    vecs[2]  = '{1'b1, 10'h002, 128'h22, 1'b1, 1'b0, 1'b1, 1'b1, 10'h002, 128'h22, 2'd1};
    vecs[3]  = '{1'b0, 10'h000, 128'h00, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 128'h00, 2'd0};
    vecs[4]  = '{1'b0, 10'h000, 128'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 128'h00, 2'd0};
    vecs[5]  = '{1'b1, 10'h003, 128'h33, 1'b0, 1'b0, 1'b1, 1'b1, 10'h003, 128'h33, 2'd1};
    vecs[6]  = '{1'b1, 10'h004, 128'h44, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 128'h00, 2'd0};
    vecs[7]  = '{1'b1, 10'h005, 128'h55, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 128'h00, 2'd0};
    vecs[8]  = '{1'b1, 10'h3FF, 128'h66, 1'b1, 1'b0, 1'b1, 1'b1, 10'h3FF, 128'h66, 2'd1};
    vecs[9]  = '{1'b0, 10'h000, 128'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h3FF, 128'h66, 2'd1};
    vecs[10] = '{1'b0, 10'h000, 128'h00, 1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 128'h00, 2'd0};

    rst_i = 1'b0;
    s_flush = 1'b0; s_out_ready = 1'b0; s_drive(1'b0, '0, '0);
    n_flush = 1'b0; n_out_ready = 1'b0;
    n_in_valid = 1'b0; n_in_ctrl = '0; n_in_data = '0;

    // Reset state, while held and after release
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_valid", s_out_valid, 0);
    check("rst_s_ready", s_in_ready, 1);
    check("rst_s_occ", s_occ, 0);
    check("rst_s_ctrl", s_out_ctrl, 0);
    check("rst_s_data", s_out_data, 0);
    check("rst_n_valid", n_out_valid, 0);
    check("rst_n_ready", n_in_ready, 1);
    rst_i = 1'b1;
    step();
    check("idle_s_occ", s_occ, 0);
    check("idle_s_ready", s_in_ready, 1);
    check("idle_n_occ", n_occ, 0);

    // SKID=0 vector table: ready checked before the edge, outputs after
    for (int i = 0; i < 11; i++) begin
      n_in_valid  = vecs[i].in_valid;
      n_in_ctrl   = vecs[i].in_ctrl;
      n_in_data   = vecs[i].in_data;
      n_out_ready = vecs[i].out_ready;
      n_flush     = vecs[i].flush;
      #1;
      check($sformatf("vec%0d_ready", i), n_in_ready, vecs[i].exp_ready);
      step();
      check($sformatf("vec%0d_valid", i), n_out_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_ctrl", i), n_out_ctrl, vecs[i].exp_ctrl);
      check($sformatf("vec%0d_data", i), n_out_data, vecs[i].exp_data);
      check($sformatf("vec%0d_occ", i), n_occ, vecs[i].exp_occ);
    end
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_flush = 1'b0;
    step();

    // SKID=1 streaming: one cycle latency, no gaps
    s_out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      s_drive(1'b1, 10'h3FF, DW'(k));
      step();
      check($sformatf("stream%0d_valid", k), s_out_valid, 1);
      check($sformatf("stream%0d_data", k), s_out_data, DW'(k));
      check($sformatf("stream%0d_occ", k), s_occ, 1);
    end
    s_drive(1'b0, '0, '0);
    step();
    check("stream_drain_occ", s_occ, 0);

    // SKID=1 backpressure: A,B fill, C held upstream, then release
    s_out_ready = 1'b0;
    s_drive(1'b1, 10'h0A1, 128'hA);
    step();
    s_drive(1'b1, 10'h0B2, 128'hB);
    step();
    check("bp_occ_full", s_occ, 2);
    check("bp_ready_low", s_in_ready, 0);
    s_drive(1'b1, 10'h0C3, 128'hC);
    step();
    step();
    check("bp_hold_data", s_out_data, 128'hA);
    check("bp_hold_occ", s_occ, 2);
    s_out_ready = 1'b1;
    step();
    check("bp_rel_b", s_out_data, 128'hB);
    check("bp_rel_ready", s_in_ready, 1);
    step();
    check("bp_rel_c", s_out_data, 128'hC);
    check("bp_rel_c_ctrl", s_out_ctrl, 10'h0C3);
    s_drive(1'b0, '0, '0);
    step();
    check("bp_empty_occ", s_occ, 0);

    // SKID=1 flush while FULL with a pending input and downstream ready
    s_out_ready = 1'b0;
    s_drive(1'b1, 10'h111, 128'h1111);
    step();
    s_drive(1'b1, 10'h222, 128'h2222);
    step();
    check("fl_pre_occ", s_occ, 2);
    s_drive(1'b1, 10'h3DD, 128'hDEAD);
    s_flush = 1'b1;
    s_out_ready = 1'b1;
    step();
    s_flush = 1'b0;
    s_drive(1'b0, '0, '0);
    check("fl_valid", s_out_valid, 0);
    check("fl_ctrl", s_out_ctrl, 0);
    check("fl_data", s_out_data, 0);
    check("fl_occ", s_occ, 0);
    check("fl_ready", s_in_ready, 1);
    repeat (3) step();
    check("fl_no_ghost", s_out_valid, 0);

    // SKID=1 async reset at occupancy 2: clears before the next edge
    s_out_ready = 1'b0;
    s_drive(1'b1, 10'h155, 128'h5555);
    step();
    s_drive(1'b1, 10'h2AA, 128'hAAAA);
    step();
    s_drive(1'b0, '0, '0);
    check("mr_pre_occ", s_occ, 2);
    rst_i = 1'b0;
    #1;
    check("mr_valid", s_out_valid, 0);
    check("mr_ctrl", s_out_ctrl, 0);
    check("mr_data", s_out_data, 0);
    check("mr_occ", s_occ, 0);
    check("mr_ready", s_in_ready, 1);
    step();
    rst_i = 1'b1;
    s_out_ready = 1'b1;
    step();
    check("mr_post_valid", s_out_valid, 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
